mul128_arbiter_ctrl: RTL and testbench
======================================

// Module: mul128_arbiter_ctrl
// PURPOSE
// Shares one 128x128 Core2 multiplier among NREQ requesters (point-add/double sequencers).
// Round-robin arbitration, operand capture, start pulse, completion detect, result return.
// Drives the core's select_line to MUL only while a product is in flight, else IDLE_SEL.
// PARAMETERS
// NREQ      2        number of requesters (2..8)
// MUL_SEL   3'b001   select_line code that routes operands to the multiplier
// IDLE_SEL  3'b000   select_line code when no multiply is in flight
// TIMEOUT   255      max cycles waiting for core busy rise or fall before abort
// PORTS
// clk           in   1          system clock, rising edge
// rst           in   1          synchronous reset, active high
// req           in   NREQ       per-requester request level; hold until done
// a_in          in   NREQ*128   operand A, slot i = a_in[i*128+:128]
// b_in          in   NREQ*128   operand B, same packing
// grant         out  NREQ       one-hot, high from capture until done
// done          out  NREQ       one-cycle pulse; result valid that cycle
// error         out  1          one-cycle pulse with done on timeout abort
// result        out  256        product of granted requester
// mul_a, mul_b  out  128        operands to core, registered
// mul_sel       out  3          core select_line
// mul_in_busy   out  1          start strobe to core (In_Busy)
// mul_out_busy  in   1          core busy (Out_Busy)
// mul_c         in   256        core product (C_Out)
// BEHAVIOUR
// - Reset: grant=0, done=0, error=0, result=0, mul_a=mul_b=0, mul_sel=IDLE_SEL,
//   mul_in_busy=0, rr pointer=0, timeout counter=0, state=IDLE.
// - FSM: IDLE -> LAUNCH -> WAIT_RISE -> WAIT_FALL -> RESP -> IDLE.
// - IDLE: if |req, pick first set bit at or after rr pointer (wrapping); latch index,
//   capture a_in/b_in slot into mul_a/mul_b, set grant bit, mul_sel=MUL_SEL -> LAUNCH.
// - LAUNCH: mul_in_busy=1 for exactly this one cycle; counter cleared -> WAIT_RISE.
// - WAIT_RISE: mul_out_busy==1 -> WAIT_FALL (counter cleared); if rise already seen in
//   LAUNCH cycle, still go through WAIT_RISE with no extra wait.
// - WAIT_FALL: mul_out_busy==0 -> register mul_c into result -> RESP.
// - RESP: done[idx]=1 one cycle, grant cleared, mul_sel=IDLE_SEL, rr pointer=idx+1
//   mod NREQ -> IDLE. Next grant earliest the cycle after RESP (no back-to-back overlap).
// - Timeout: counter increments each cycle in WAIT_RISE/WAIT_FALL; reaching TIMEOUT
//   -> RESP with result=0, error=1 alongside done.
// - Operands frozen in mul_a/mul_b from capture to RESP; req/a_in changes ignored.
// - req dropped by granted requester mid-operation: operation completes, done still pulses.
// - Requests arriving during an operation wait; fairness: each active requester served
//   within NREQ operations.
// - Latency: req high in IDLE -> done = 4 + core busy-high cycles (min 5 cycles).
// - rst mid-operation: all outputs to reset values next edge; no done; core left to drain,
//   mul_in_busy not reissued until a new grant.
// - done and grant never high for two requesters simultaneously.
// TESTING
// - Single req[0], A=2^127, B=2, core model busy 10 cyc -> done[0] once, result=2^128, error=0.
// - req=2'b11 held, 4 ops -> grants 0,1,0,1; each done single-cycle, grants one-hot.
// - A=B=2^128-1 -> result=2^256-2^129+1; mul_sel=MUL_SEL only LAUNCH..WAIT_FALL.
// - Core model never raises busy -> after TIMEOUT cycles done+error, result=0; next req OK.
// - rst asserted in WAIT_FALL -> next cycle all outputs at reset values, no done pulse.
// - req[1] drops during WAIT_FALL -> done[1] still pulses; rr pointer advances to 0.

Source files
------------

// File: rtl/mul128_arbiter_ctrl_if.sv
// Requester-side and core-side signals of the shared 128x128 multiplier controller.
// The slave modport is the controller; the master modport drives requests and models the core.
interface mul128_arbiter_ctrl_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]     req;
  logic [NREQ*128-1:0] a_in;
  logic [NREQ*128-1:0] b_in;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     done;
  logic                error;
  logic [255:0]        result;
  logic [127:0]        mul_a;
  logic [127:0]        mul_b;
  logic [2:0]          mul_sel;
  logic                mul_in_busy;
  logic                mul_out_busy;
  logic [255:0]        mul_c;

  modport slave (
    input  req, a_in, b_in, mul_out_busy, mul_c,
    output grant, done, error, result, mul_a, mul_b, mul_sel, mul_in_busy
  );

  modport master (
    output req, a_in, b_in, mul_out_busy, mul_c,
    input  grant, done, error, result, mul_a, mul_b, mul_sel, mul_in_busy
  );
endinterface

// File: rtl/mul128_arbiter_ctrl.sv
// Round-robin sharing of one 128x128 multiplier core among NREQ requesters:
// operand capture, start strobe, busy-edge tracking with timeout, result return.
module mul128_arbiter_ctrl #(
  parameter int         NREQ     = 2,
  parameter logic [2:0] MUL_SEL  = 3'b001,
  parameter logic [2:0] IDLE_SEL = 3'b000,
  parameter int         TIMEOUT  = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  mul128_arbiter_ctrl_if.slave  bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_RISE,
    WAIT_FALL,
    RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  int            slot;

  // Scan offsets from the far end down so the nearest set bit at or after rr_ptr wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    slot       = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      slot = (int'(rr_ptr) + k) % NREQ;
      if (bus.req[slot]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(slot);
      end
    end
  end

  logic          rise_seen;
  logic          fall_seen;
  logic          timed_out;
  logic [IW-1:0] rr_next;

  assign rise_seen = (state == WAIT_RISE) && bus.mul_out_busy;
  assign fall_seen = (state == WAIT_FALL) && !bus.mul_out_busy;
  assign timed_out = (cnt == CW'(TIMEOUT - 1));
  assign rr_next   = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;

  // NOTE: all state and outputs update with <= so every branch sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      idx             <= '0;
      cnt             <= '0;
      bus.grant       <= '0;
      bus.done        <= '0;
      bus.error       <= 1'b0;
      bus.result      <= '0;
      bus.mul_a       <= '0;
      bus.mul_b       <= '0;
      bus.mul_sel     <= IDLE_SEL;
      bus.mul_in_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            idx             <= pick_idx;
            bus.mul_a       <= bus.a_in[int'(pick_idx)*128 +: 128];
            bus.mul_b       <= bus.b_in[int'(pick_idx)*128 +: 128];
            bus.grant       <= NREQ'(1) << pick_idx;
            bus.mul_sel     <= MUL_SEL;
            bus.mul_in_busy <= 1'b1;
            state           <= LAUNCH;
          end
        end
        LAUNCH: begin
          bus.mul_in_busy <= 1'b0;
          cnt             <= '0;
          state           <= WAIT_RISE;
        end
        WAIT_RISE, WAIT_FALL: begin
          if (rise_seen) begin
            cnt   <= '0;
            state <= WAIT_FALL;
          end else if (fall_seen || timed_out) begin
            // A timeout abort returns a zero product flagged by error.
            bus.result  <= fall_seen ? bus.mul_c : '0;
            bus.error   <= !fall_seen;
            bus.done    <= NREQ'(1) << idx;
            bus.grant   <= '0;
            bus.mul_sel <= IDLE_SEL;
            rr_ptr      <= rr_next;
            state       <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          bus.done  <= '0;
          bus.error <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul128_arbiter_ctrl.sv
// Directed bench for mul128_arbiter_ctrl with a behavioural multiplier core whose
// busy length can be set or disabled entirely to force the timeout path.
module tb_mul128_arbiter_ctrl;
  localparam int         NREQ     = 2;
  localparam logic [2:0] MUL_SEL  = 3'b001;
  localparam logic [2:0] IDLE_SEL = 3'b000;
  localparam int         TIMEOUT  = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  int           busy_len  = 10;
  logic         core_dead = 1'b0;
  int           core_cnt  = 0;
  logic [255:0] core_prod = '0;

  mul128_arbiter_ctrl_if #(.NREQ(NREQ)) bus ();

  mul128_arbiter_ctrl #(
    .NREQ    (NREQ),
    .MUL_SEL (MUL_SEL),
    .IDLE_SEL(IDLE_SEL),
    .TIMEOUT (TIMEOUT)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Core model: a start strobe loads busy_len busy cycles and latches the product.
  assign bus.mul_out_busy = (core_cnt != 0);
  assign bus.mul_c        = core_prod;

  always @(posedge clk) begin
    if (bus.mul_in_busy && !core_dead) begin
      core_cnt  <= busy_len;
      core_prod <= {128'b0, bus.mul_a} * {128'b0, bus.mul_b};
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (bus.grant == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant_seen"}, 256'(bus.grant != '0), 256'(1));
  endtask

  // Follows one operation from grant to done and the idle cycle after it.
  task automatic run_op(input string tag, input int gi, input logic [255:0] exp_res,
                        input logic exp_err, input int exp_pulses, output int cycles);
    int   n      = 0;
    int   pulses = 0;
    logic sel_ok = 1'b1;
    while (bus.grant == '0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_grant"}, 256'(bus.grant), 256'(1) << gi);
    n = 0;
    while (bus.done == '0 && n < 600) begin
      if (bus.mul_sel !== MUL_SEL || bus.grant !== NREQ'(1 << gi)) sel_ok = 1'b0;
      if (bus.mul_in_busy) pulses++;
      @(negedge clk);
      n++;
    end
    cycles = n;
    check({tag, "_done"},     256'(bus.done),     256'(1) << gi);
    check({tag, "_result"},   bus.result,         exp_res);
    check({tag, "_error"},    256'(bus.error),    256'(exp_err));
    check({tag, "_sel_resp"}, 256'(bus.mul_sel),  256'(IDLE_SEL));
    check({tag, "_grant_off"},256'(bus.grant),    256'(0));
    check({tag, "_sel_busy"}, 256'(sel_ok),       256'(1));
    check({tag, "_pulses"},   256'(pulses),       256'(exp_pulses));
    @(negedge clk);
    check({tag, "_done_one"}, 256'(bus.done),     256'(0));
    check({tag, "_err_one"},  256'(bus.error),    256'(0));
  endtask

  initial begin
    logic [255:0] p128;
    logic [255:0] pmax;
    logic         saw_done;
    logic         saw_start;
    logic         saw_grant;
    int           cyc;

    p128 = 256'(1) << 128;
    pmax = {128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 128'h0000_0000_0000_0000_0000_0000_0000_0001};

    bus.req  = '0;
    bus.a_in = '0;
    bus.b_in = '0;
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_grant",  256'(bus.grant),       256'(0));
    check("rst_done",   256'(bus.done),        256'(0));
    check("rst_error",  256'(bus.error),       256'(0));
    check("rst_result", bus.result,            256'(0));
    check("rst_mul_a",  256'(bus.mul_a),       256'(0));
    check("rst_mul_b",  256'(bus.mul_b),       256'(0));
    check("rst_sel",    256'(bus.mul_sel),     256'(IDLE_SEL));
    check("rst_start",  256'(bus.mul_in_busy), 256'(0));
    rst = 1'b0;
    @(negedge clk);

    // 2^127 * 2, with the input operands scrambled after capture.
    busy_len        = 10;
    bus.a_in[127:0] = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
    bus.b_in[127:0] = 128'd2;
    bus.req         = 2'b01;
    wait_grant("t1");
    bus.a_in = '1;
    bus.b_in = '1;
    run_op("t1", 0, p128, 1'b0, 1, cyc);
    bus.req = '0;
    check("t1_mul_a_frozen", 256'(bus.mul_a), 256'(128'h8000_0000_0000_0000_0000_0000_0000_0000));

    // Round robin from a fresh pointer with both requests held.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.a_in = {128'd7, 128'd3};
    bus.b_in = {128'd11, 128'd5};
    bus.req  = 2'b11;
    run_op("rr0", 0, 256'd15, 1'b0, 1, cyc);
    run_op("rr1", 1, 256'd77, 1'b0, 1, cyc);
    run_op("rr2", 0, 256'd15, 1'b0, 1, cyc);
    run_op("rr3", 1, 256'd77, 1'b0, 1, cyc);
    bus.req = '0;

    // Maximum operands.
    bus.a_in[127:0] = '1;
    bus.b_in[127:0] = '1;
    bus.req         = 2'b01;
    run_op("max", 0, pmax, 1'b0, 1, cyc);
    bus.req = '0;

    // Dead core forces a timeout abort, then a normal operation still works.
    core_dead = 1'b1;
    bus.req   = 2'b01;
    run_op("tmo", 0, 256'd0, 1'b1, 1, cyc);
    bus.req   = '0;
    core_dead = 1'b0;
    check("tmo_cycles", 256'(cyc >= TIMEOUT && cyc <= TIMEOUT + 5), 256'(1));
    bus.req = 2'b10;
    run_op("tmo_next", 1, 256'd77, 1'b0, 1, cyc);
    bus.req = '0;

    // Reset while the core is busy in WAIT_FALL.
    busy_len        = 20;
    bus.a_in[127:0] = 128'd3;
    bus.b_in[127:0] = 128'd5;
    bus.req         = 2'b01;
    wait_grant("mrst");
    repeat (6) @(negedge clk);
    rst     = 1'b1;
    bus.req = '0;
    @(negedge clk);
    check("mrst_grant",  256'(bus.grant),       256'(0));
    check("mrst_done",   256'(bus.done),        256'(0));
    check("mrst_result", bus.result,            256'(0));
    check("mrst_mul_a",  256'(bus.mul_a),       256'(0));
    check("mrst_sel",    256'(bus.mul_sel),     256'(IDLE_SEL));
    check("mrst_start",  256'(bus.mul_in_busy), 256'(0));
    rst       = 1'b0;
    saw_done  = 1'b0;
    saw_start = 1'b0;
    saw_grant = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done != '0)  saw_done  = 1'b1;
      if (bus.mul_in_busy) saw_start = 1'b1;
      if (bus.grant != '0) saw_grant = 1'b1;
    end
    check("mrst_no_done",  256'(saw_done),  256'(0));
    check("mrst_no_start", 256'(saw_start), 256'(0));
    check("mrst_no_grant", 256'(saw_grant), 256'(0));

    // Requester 1 drops its request mid-operation; pointer then wraps to 0.
    busy_len = 10;
    bus.req  = 2'b10;
    wait_grant("drop");
    repeat (5) @(negedge clk);
    bus.req = '0;
    run_op("drop", 1, 256'd77, 1'b0, 0, cyc);
    bus.req = 2'b11;
    run_op("wrap", 0, 256'd15, 1'b0, 1, cyc);
    bus.req = '0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
